// File: rtl/reg_bank.sv
// Eight-entry register bank R0..R7; R7 is the PC with its own increment path.
// Optional multi-hot select checking: define REG_BANK_ONEHOT_CHK_EN.
module reg_bank #(
    parameter int          DW       = 16,
    parameter int unsigned PC_RESET = 0
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic [0:7]    Rin,
    input  logic [DW-1:0] Din,
    input  logic          pc_incr,
    input  logic [0:7]    Rsel,
    output logic [DW-1:0] Dout,
    output logic [DW-1:0] PC,
    output logic          sel_err
);

    localparam logic [DW-1:0] PC_RST = DW'(PC_RESET);

    logic [DW-1:0] r_q [0:7];
    logic [DW-1:0] r_d [0:7];
    logic          rin_multi;
    logic          rsel_multi;
    logic          wr_ok;
    logic [DW-1:0] rd_or;

    // Multi-hot detection: clearing the lowest set bit leaves something.
    always_comb begin
        rin_multi  = ((Rin & (Rin - 8'd1)) != 8'd0);
        rsel_multi = ((Rsel & (Rsel - 8'd1)) != 8'd0);
    end

`ifdef REG_BANK_ONEHOT_CHK_EN
    logic sel_err_q;
    logic sel_err_d;

    assign wr_ok = ~rin_multi;

    // Sticky error: any multi-hot write or read select seen at an edge.
    always_comb begin
        sel_err_d = sel_err_q | rin_multi | rsel_multi;
    end

    // Error flag register, cleared only by reset.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            sel_err_q <= 1'b0;
        end else begin
            sel_err_q <= sel_err_d;
        end
    end

    assign sel_err = sel_err_q;
`else
    assign wr_ok   = 1'b1;
    assign sel_err = 1'b0;
`endif

    // Next state: bus writes, then the PC increment unless R7 is written.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            r_d[i] = r_q[i];
            if (wr_ok && Rin[i]) begin
                r_d[i] = Din;
            end
        end
        if (pc_incr && !Rin[7]) begin
            r_d[7] = r_q[7] + DW'(1);
        end
    end

    // Register file state; R7 resets to the PC start address.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < 7; i++) begin
                r_q[i] <= '0;
            end
            r_q[7] <= PC_RST;
        end else begin
            for (int i = 0; i < 8; i++) begin
                r_q[i] <= r_d[i];
            end
        end
    end

    // Read path: OR of all selected registers, no write bypass.
    always_comb begin
        rd_or = '0;
        for (int i = 0; i < 8; i++) begin
            if (Rsel[i]) begin
                rd_or = rd_or | r_q[i];
            end
        end
`ifdef REG_BANK_ONEHOT_CHK_EN
        Dout = rsel_multi ? '0 : rd_or;
`else
        Dout = rd_or;
`endif
    end

    assign PC = r_q[7];

endmodule

// File: tb/tb_reg_bank.sv
// Directed bench for reg_bank with PC_RESET = 16'h0040.
// Multi-hot expectations follow REG_BANK_ONEHOT_CHK_EN when defined.
module tb_reg_bank;

    logic        Clock;
    logic        Reset;
    logic [0:7]  Rin;
    logic [15:0] Din;
    logic        pc_incr;
    logic [0:7]  Rsel;
    logic [15:0] Dout;
    logic [15:0] PC;
    logic        sel_err;

    int checks = 0;
    int errors = 0;

    reg_bank #(
        .DW       (16),
        .PC_RESET (32'h0040)
    ) dut (
        .Clock   (Clock),
        .Reset   (Reset),
        .Rin     (Rin),
        .Din     (Din),
        .pc_incr (pc_incr),
        .Rsel    (Rsel),
        .Dout    (Dout),
        .PC      (PC),
        .sel_err (sel_err)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic rd(input int idx, input string tag,
                      input logic [15:0] exp);
        Rsel = '0;
        Rsel[idx] = 1'b1;
        #1;
        chk(tag, Dout, exp);
    endtask

    initial begin
        Reset   = 1'b1;
        Rin     = '0;
        Din     = '0;
        pc_incr = 1'b0;
        Rsel    = '0;
        #3;
        chk("rst_dout_nosel", Dout, 16'h0000);
        chk("rst_pc", PC, 16'h0040);
        chk("rst_sel_err", {15'd0, sel_err}, 16'h0000);
        for (int i = 0; i < 7; i++) begin
            rd(i, $sformatf("rst_r%0d", i), 16'h0000);
        end
        rd(7, "rst_r7", 16'h0040);
        Rsel = '0;
        tick();
        Reset = 1'b0;

        // Write R2
        Rin = 8'b00100000;
        Din = 16'hA5A5;
        tick();
        Rin = '0;
        rd(2, "wr_r2", 16'hA5A5);
        rd(0, "wr_r0_clean", 16'h0000);
        rd(1, "wr_r1_clean", 16'h0000);
        for (int i = 3; i < 7; i++) begin
            rd(i, $sformatf("wr_r%0d_clean", i), 16'h0000);
        end
        chk("wr_pc_clean", PC, 16'h0040);

        // PC wrap, write-wins, increment, concurrent write
        Rin = 8'b00000001;
        Din = 16'hFFFF;
        tick();
        chk("pc_load_ffff", PC, 16'hFFFF);
        Rin = '0;
        pc_incr = 1'b1;
        tick();
        chk("pc_wrap", PC, 16'h0000);
        Rin = 8'b00000001;
        Din = 16'h1234;
        tick();
        chk("pc_write_wins", PC, 16'h1234);
        Rin = '0;
        tick();
        chk("pc_incr", PC, 16'h1235);
        Rin = 8'b00001000;
        Din = 16'hBEEF;
        tick();
        chk("pc_incr_concurrent", PC, 16'h1236);
        pc_incr = 1'b0;
        Rin = '0;
        rd(4, "r4_concurrent", 16'hBEEF);
        tick();
        chk("pc_hold", PC, 16'h1236);

        // Read-during-write returns old value
        Rin  = 8'b10000000;
        Din  = 16'h0007;
        Rsel = 8'b10000000;
        #1;
        chk("rdw_old", Dout, 16'h0000);
        tick();
        Rin = '0;
        chk("rdw_new", Dout, 16'h0007);

        // Multi-hot read select: R0 | R2
        Rsel = 8'b10100000;
        #1;
`ifdef REG_BANK_ONEHOT_CHK_EN
        chk("rsel_multi_dout", Dout, 16'h0000);
`else
        chk("rsel_multi_dout", Dout, 16'hA5A7);
`endif
        chk("rsel_multi_err_pre", {15'd0, sel_err}, 16'h0000);
        tick();
        Rsel = '0;
`ifdef REG_BANK_ONEHOT_CHK_EN
        chk("rsel_multi_err", {15'd0, sel_err}, 16'h0001);
`else
        chk("rsel_multi_err", {15'd0, sel_err}, 16'h0000);
`endif

        // Async reset between edges
        Rin = 8'b00010000;
        Din = 16'h00F0;
        tick();
        Rin = '0;
        rd(3, "r3_before_rst", 16'h00F0);
        #1;
        Reset = 1'b1;
        #1;
        chk("async_rst_r3", Dout, 16'h0000);
        chk("async_rst_pc", PC, 16'h0040);
        chk("async_rst_err", {15'd0, sel_err}, 16'h0000);
        Rin = 8'b00010000;
        pc_incr = 1'b1;
        tick();
        chk("rst_hold_r3", Dout, 16'h0000);
        chk("rst_hold_pc", PC, 16'h0040);
        Rin = '0;
        Rsel = '0;
        Reset = 1'b0;

        // Multi-hot write on the first edge after reset release
        Rin = 8'b11000000;
        Din = 16'h5555;
        pc_incr = 1'b1;
        tick();
        Rin = '0;
        pc_incr = 1'b0;
        chk("multi_wr_pc_incr", PC, 16'h0041);
`ifdef REG_BANK_ONEHOT_CHK_EN
        chk("multi_wr_err", {15'd0, sel_err}, 16'h0001);
        rd(0, "multi_wr_r0", 16'h0000);
        rd(1, "multi_wr_r1", 16'h0000);
`else
        chk("multi_wr_err", {15'd0, sel_err}, 16'h0000);
        rd(0, "multi_wr_r0", 16'h5555);
        rd(1, "multi_wr_r1", 16'h5555);
`endif
        rd(2, "multi_wr_r2", 16'h0000);
        Rsel = '0;
        #1;
        chk("end_dout_nosel", Dout, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
